dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bus bridge sitting directly downstream of the pipeline's M stage. It takes the word-aligned load/store request (`alu_out_M`, `write_data_M`, `byte_en_M`) and runs it as a registered req/ack transaction on the data bus. It returns the fetched word as `read_data_M` and drives `data_mem_ack`, which the hazard unit uses to stall the pipeline while an access is outstanding. An optional watchdog terminates transactions whose slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, 255: bus cycles in REQ before the watchdog fires; legal range 1..2^CNT_W-1.
- `CNT_W`, 8: watchdog counter width.
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `read_data_M` for a timed-out load.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mem_rd_M`  in  1  load in M stage.
- `mem_wr_M`  in  1  store in M stage; `mem_rd_M` and `mem_wr_M` are never both high.
- `stall_M`  in  1  M-stage register held this cycle.
- `flush_M`  in  1  M-stage instruction squashed.
- `alu_out_M`  in  32  byte address.
- `write_data_M`  in  32  store data, already lane-replicated.
- `byte_en_M`  in  4  lane enables.
- `read_data_M`  out  32  load data to the M/W path.
- `data_mem_ack`  out  1  high = no access pending or access complete.
- `bus_req`  out  1  request strobe, registered.
- `bus_we`  out  1  write strobe, registered.
- `bus_addr`  out  32  `{alu_out_M[31:2],2'b00}`, registered.
- `bus_wdata`  out  32  registered store data.
- `bus_be`  out  4  registered lane enables; forced to 4'hF on loads.
- `bus_rdata`  in  32  slave read data, valid with `bus_ack`.
- `bus_ack`  in  1  slave completion, single-cycle pulse.
- `bus_err`  out  1  sticky timeout flag. Cleared only by reset. Present only with `DMEM_WDOG_EN`.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- **Reset (`reset`=0 at an edge):** state goes to IDLE. `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0, `read_data_M`=0, `bus_err`=0, watchdog counter=0. Reset taken mid-REQ drops `bus_req` on that edge; a late `bus_ack` arriving in IDLE is ignored.
- **IDLE:**
  - `data_mem_ack` = ~(`mem_rd_M`|`mem_wr_M`) | `flush_M`.
  - If (`mem_rd_M`|`mem_wr_M`) & ~`flush_M`: latch the bus fields, set `bus_req`=1 and `bus_we`=`mem_wr_M`, clear the counter, and go to REQ.
- **REQ:**
  - `data_mem_ack`=0 and `bus_req` stays high.
  - Each cycle without `bus_ack`, the counter increments.
  - On `bus_ack`=1: drop `bus_req`/`bus_we`. For a load, capture `bus_rdata` into the `read_data_M` register; for a store, `read_data_M` is unchanged. Go to DONE.
  - `flush_M` and `stall_M` are ignored in REQ. A started transaction always completes.
- **DONE:**
  - `data_mem_ack`=1 and `read_data_M` holds the captured value.
  - If `stall_M`=0 or `flush_M`=1, go to IDLE; otherwise stay in DONE. A held instruction is never re-issued.
- Byte/halfword sign extension is not done here; it belongs to the M-stage logic. Misalignment is not checked.

## Timing
- Minimum load latency is 3 cycles:
  - Cycle 0: IDLE sees the request, with ack low.
  - Cycle 1: REQ, and the slave may ack.
  - Cycle 2: DONE with ack high; the pipeline advances at the end of cycle 2.
- With a slave acking n cycles after `bus_req` rises (n≥0), `data_mem_ack` is low for n+2 cycles.
- `bus_*` outputs are registered. `data_mem_ack` is combinational from state, `mem_rd_M`, `mem_wr_M` and `flush_M`.
- Back-to-back accesses: DONE→IDLE takes one cycle, so the next request starts one cycle after the previous one completes.

## Configuration
- **`DMEM_WDOG_EN` defined:**
  - In REQ, when the counter reaches `TIMEOUT` with no `bus_ack`: drop `bus_req`, set `bus_err`=1 (sticky), load `ERR_DATA` into `read_data_M` for loads, and go to DONE.
  - If `bus_ack` and the timeout land on the same cycle, `bus_ack` wins and `bus_err` is not set.
- **`DMEM_WDOG_EN` undefined:** no counter and no `bus_err` port; REQ waits indefinitely.

## Test plan
- **Reset then idle:** `reset`=0 for 2 cycles, then no requests -> all outputs 0 and `data_mem_ack`=1 continuously.
- **Zero-wait load:** `mem_rd_M`=1, `alu_out_M`=32'h0000_1006, slave acks same cycle as `bus_req` with `bus_rdata`=32'hCAFE_F00D -> `bus_addr`=32'h0000_1004, `bus_be`=4'hF, `data_mem_ack` low 2 cycles, then `read_data_M`=32'hCAFE_F00D with ack high.
- **Wait-stated store:** `mem_wr_M`=1, `write_data_M`=32'h1111_2222, `byte_en_M`=4'b0011, slave acks after 5 cycles -> `bus_we`=1 with `bus_be`=4'b0011 for 6 cycles, ack low 7 cycles, exactly one bus transaction.
- **Held in DONE:** complete a load while `stall_M`=1 for 3 cycles -> stays in DONE with ack high, no second `bus_req`; returns to IDLE the cycle `stall_M` drops.
- **Flush and reset:** `flush_M`=1 with `mem_rd_M`=1 in IDLE -> no `bus_req`. Reset asserted in REQ, then `bus_ack` one cycle later -> IDLE, `bus_req`=0, ack ignored.
- **Watchdog (`DMEM_WDOG_EN`, `TIMEOUT`=4):** load with no slave ack -> `bus_req` drops after 4 REQ cycles, `bus_err`=1, `read_data_M`=32'hDEAD_BEEF; a subsequent acked load keeps `bus_err`=1.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory bus bridge: runs M-stage load/store requests as registered req/ack bus transactions.
// Optional watchdog (TIMEOUT, ERR_DATA, bus_err) is built only when DMEM_WDOG_EN is defined.
module dmem_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic        stall_M,
    input  logic        flush_M,
    input  logic [31:0] alu_out_M,
    input  logic [31:0] write_data_M,
    input  logic [3:0]  byte_en_M,
    output logic [31:0] read_data_M,
    output logic        data_mem_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
`ifdef DMEM_WDOG_EN
    output logic        bus_err,
`endif
    input  logic        bus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic        w_timeout;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_read_data;
    logic        r_is_load;

    assign w_start = (mem_rd_M | mem_wr_M) & ~flush_M;

`ifdef DMEM_WDOG_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Fires on the TIMEOUT-th REQ cycle without an ack.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_err   = r_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (bus_ack || w_timeout) w_next = S_DONE;
            S_DONE:  if (!stall_M || flush_M) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        data_mem_ack = 1'b1;
        case (r_state)
            S_IDLE:  data_mem_ack = ~(mem_rd_M | mem_wr_M) | flush_M;
            S_REQ:   data_mem_ack = 1'b0;
            default: data_mem_ack = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_read_data <= '0;
            r_is_load   <= 1'b0;
`ifdef DMEM_WDOG_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_wr_M;
                        r_bus_addr  <= {alu_out_M[31:2], 2'b00};
                        r_bus_wdata <= write_data_M;
                        r_bus_be    <= mem_rd_M ? 4'hF : byte_en_M;
                        r_is_load   <= mem_rd_M;
`ifdef DMEM_WDOG_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // An ack on the timeout cycle still counts as a normal completion.
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (r_is_load) r_read_data <= bus_rdata;
                    end
`ifdef DMEM_WDOG_EN
                    else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_err     <= 1'b1;
                        if (r_is_load) r_read_data <= ERR_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_be      = r_bus_be;
    assign read_data_M = r_read_data;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus pushes expected transactions, a negedge monitor checks completions.
module tb_dmem_bridge;

`ifdef DMEM_WDOG_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_M, mem_wr_M, stall_M, flush_M;
    logic [31:0] alu_out_M, write_data_M;
    logic [3:0]  byte_en_M;
    logic [31:0] read_data_M;
    logic        data_mem_ack;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
`ifdef DMEM_WDOG_EN
    logic        bus_err;
`endif

    dmem_bridge #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M), .stall_M(stall_M), .flush_M(flush_M),
        .alu_out_M(alu_out_M), .write_data_M(write_data_M), .byte_en_M(byte_en_M),
        .read_data_M(read_data_M), .data_mem_ack(data_mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata),
`ifdef DMEM_WDOG_EN
        .bus_err(bus_err),
`endif
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          low;
        int          req_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          slave_lat    = 0;
    logic [31:0] slave_data   = '0;
    logic        slave_manual = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: acks slave_lat cycles after bus_req is first seen high; slave_lat < 0 never acks.
    initial begin
        int cnt;
        cnt       = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            if (!slave_manual) begin
                if (bus_req) begin
                    if (cnt == slave_lat) begin
                        bus_ack   = 1'b1;
                        bus_rdata = slave_data;
                    end else begin
                        bus_ack   = 1'b0;
                        bus_rdata = 32'h5A5A_5A5A;
                    end
                    cnt++;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = 32'h5A5A_5A5A;
                    cnt       = 0;
                end
            end
        end
    end

    // Monitor: a rise of data_mem_ack marks a completed transaction.
    initial begin
        logic        prev_ack, prev_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        int          low, rcyc, wcyc, rises;
        exp_t        e;
        prev_ack = 1'b1; prev_req = 1'b0;
        low = 0; rcyc = 0; wcyc = 0; rises = 0;
        c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                low = 0; rcyc = 0; wcyc = 0; rises = 0;
                prev_ack = 1'b1; prev_req = 1'b0;
            end else begin
                if (bus_req && !prev_req) begin
                    rises++;
                    c_addr = bus_addr; c_we = bus_we; c_be = bus_be; c_wdata = bus_wdata;
                end
                if (bus_req) rcyc++;
                if (bus_we) wcyc++;
                if (!data_mem_ack) low++;
                if (data_mem_ack && !prev_ack) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("read_data_M", read_data_M, e.rdata);
                        chk("bus_addr", c_addr, e.addr);
                        chk("bus_we", c_we, e.we);
                        chk("bus_be", c_be, e.be);
                        if (e.we) chk("bus_wdata", c_wdata, e.wdata);
                        chk("ack_low_cycles", low, e.low);
                        chk("req_cycles", rcyc, e.req_cyc);
                        chk("we_cycles", wcyc, e.we ? e.req_cyc : 0);
                        chk("req_rises", rises, 1);
                    end
                    low = 0; rcyc = 0; wcyc = 0; rises = 0;
                end
                prev_ack = data_mem_ack;
                prev_req = bus_req;
            end
        end
    end

    task automatic push(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int low, input int req_cyc);
        exp_t e;
        e.addr = addr; e.we = we; e.be = be; e.wdata = wdata;
        e.rdata = rdata; e.low = low; e.req_cyc = req_cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int lat, input logic [31:0] srdata, input int stall_cyc);
        logic seen_low;
        bit   done;
        @(posedge clk); #1;
        slave_lat = lat; slave_data = srdata;
        mem_rd_M = rd; mem_wr_M = wr; alu_out_M = addr; write_data_M = wdata;
        byte_en_M = be; stall_M = (stall_cyc > 0);
        seen_low = 1'b0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!data_mem_ack) seen_low = 1'b1;
            else if (seen_low) done = 1;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL access_timeout: got no completion expected completion at %0t", $time);
        end
        if (stall_cyc > 0) begin
            for (int k = 1; k < stall_cyc; k++) begin
                @(negedge clk);
                chk("held_ack", data_mem_ack, 1'b1);
                chk("held_no_req", bus_req, 1'b0);
            end
            @(posedge clk); #1;
            stall_M = 1'b0;
            @(negedge clk);
            chk("release_ack", data_mem_ack, 1'b1);
        end
        @(posedge clk); #1;
        mem_rd_M = 1'b0; mem_wr_M = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0;
        mem_rd_M = 0; mem_wr_M = 0; stall_M = 0; flush_M = 0;
        alu_out_M = '0; write_data_M = '0; byte_en_M = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_be", bus_be, 4'h0);
        chk("rst_read_data", read_data_M, 32'h0);
        chk("rst_ack", data_mem_ack, 1'b1);
`ifdef DMEM_WDOG_EN
        chk("rst_bus_err", bus_err, 1'b0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack", data_mem_ack, 1'b1);
            chk("idle_req", bus_req, 1'b0);
        end

        // Zero-wait load.
        push(32'h0000_1004, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 1);
        do_access(1, 0, 32'h0000_1006, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 0);

        // Wait-stated store; read_data_M keeps the last load value.
        push(32'h0000_2000, 1'b1, 4'b0011, 32'h1111_2222, 32'hCAFE_F00D, 7, 6);
        do_access(0, 1, 32'h0000_2000, 32'h1111_2222, 4'b0011, 5, 32'h0, 0);

        // Load at top of address space, 2 wait states.
        push(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 4, 3);
        do_access(1, 0, 32'hFFFF_FFFF, 32'h0, 4'h0, 2, 32'h1234_5678, 0);

        // Upper-lane store, zero wait.
        push(32'h0000_0040, 1'b1, 4'b1100, 32'hAB00_CD00, 32'h1234_5678, 2, 1);
        do_access(0, 1, 32'h0000_0041, 32'hAB00_CD00, 4'b1100, 0, 32'h0, 0);

        // Load completing while stalled for 3 cycles in DONE.
        push(32'h0000_3008, 1'b0, 4'hF, 32'h0, 32'h8765_4321, 3, 2);
        do_access(1, 0, 32'h0000_3008, 32'h0, 4'h0, 1, 32'h8765_4321, 3);
        @(negedge clk);
        chk("post_stall_no_req", bus_req, 1'b0);
        chk("post_stall_ack", data_mem_ack, 1'b1);

        // Flushed request in IDLE starts nothing.
        @(posedge clk); #1;
        mem_rd_M = 1; flush_M = 1; alu_out_M = 32'h0000_5000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_ack", data_mem_ack, 1'b1);
            chk("flush_no_req", bus_req, 1'b0);
        end
        @(posedge clk); #1;
        mem_rd_M = 0; flush_M = 0;

        // Reset taken in REQ, then a late ack in IDLE.
        slave_manual = 1'b1;
        @(posedge clk); #1;
        mem_rd_M = 1; alu_out_M = 32'h0000_6000;
        @(posedge clk); #1;
        mem_rd_M = 0; reset = 1'b0;
        @(negedge clk);
        chk("midreq_req_before_reset", bus_req, 1'b1);
        @(negedge clk);
        chk("midreq_reset_req", bus_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("late_ack_data_ack", data_mem_ack, 1'b1);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_no_req", bus_req, 1'b0);
        chk("late_ack_read_data", read_data_M, 32'h0);
        chk("late_ack_idle_ack", data_mem_ack, 1'b1);
        slave_manual = 1'b0;

`ifdef DMEM_WDOG_EN
        // Unacked load times out after 4 REQ cycles.
        push(32'h0000_7000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 5, 4);
        do_access(1, 0, 32'h0000_7000, 32'h0, 4'h0, -1, 32'h0, 0);
        @(negedge clk);
        chk("wdog_bus_err", bus_err, 1'b1);
        push(32'h0000_7004, 1'b0, 4'hF, 32'h0, 32'h0BAD_C0DE, 3, 2);
        do_access(1, 0, 32'h0000_7004, 32'h0, 4'h0, 1, 32'h0BAD_C0DE, 0);
        @(negedge clk);
        chk("wdog_err_sticky", bus_err, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
